// File: rtl/step_decoder_pkg.sv
// Shared types and default widths for the step decoder.
package step_decoder_pkg;

  localparam int DEF_PERIOD_W = 17;
  localparam int DEF_POS_W    = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    MEASURE = 2'd2,
    STALLED = 2'd3
  } state_t;

endpackage

// File: rtl/step_decoder_sync_edge.sv
// Two-flop synchronizer with optional rising-edge detect (EDGE=1) or level pass-through (EDGE=0).
module sync_edge #(
  parameter bit EDGE = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic q
);

  logic       meta_p0;
  logic       sync_p1;
  logic       last_p2;
  logic [2:0] prime;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      last_p2 <= 1'b0;
      prime   <= 3'b000;
    end else begin
      meta_p0 <= din;
      sync_p1 <= meta_p0;
      last_p2 <= sync_p1;
      prime   <= {prime[1:0], 1'b1};
    end
  end

  // Edges are only trusted once last_p2 holds a real sample, so an input already
  // high at reset release never looks like a rising edge.
  assign q = EDGE ? (sync_p1 & ~last_p2 & prime[2]) : sync_p1;

endmodule

// File: rtl/step_decoder.sv
// Step/direction decoder: measures clk counts between step edges, tracks signed position, flags stalls.
module step_decoder
  import step_decoder_pkg::*;
#(
  parameter int PERIOD_W = DEF_PERIOD_W,
  parameter int POS_W    = DEF_POS_W,
  parameter int TIMEOUT  = 100000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                drv_step,
  input  logic                drv_dir,
  input  logic                drv_enable_SM,
  input  logic                clr_pos,
  output logic [PERIOD_W-1:0] period,
  output logic                period_valid,
  output logic [POS_W-1:0]    position,
  output logic                timeout
);

  localparam logic [PERIOD_W-1:0] LIMIT = PERIOD_W'(TIMEOUT);
  localparam logic [PERIOD_W-1:0] ONE   = PERIOD_W'(1);

  function automatic logic signed [POS_W-1:0] step_pos(
    input logic signed [POS_W-1:0] cur,
    input logic                    fwd
  );
    return fwd ? (cur + POS_W'(1)) : (cur - POS_W'(1));
  endfunction

  logic                     step_rise;
  logic                     dir_lvl;
  logic                     counted;
  state_t                   state;
  logic [PERIOD_W-1:0]      count;
  logic signed [POS_W-1:0]  pos_acc;

  sync_edge #(.EDGE(1'b1)) u_step (
    .clk (clk),
    .rst (rst),
    .din (drv_step),
    .q   (step_rise)
  );

  sync_edge #(.EDGE(1'b0)) u_dir (
    .clk (clk),
    .rst (rst),
    .din (drv_dir),
    .q   (dir_lvl)
  );

  assign counted  = step_rise && drv_enable_SM && (state != IDLE);
  assign position = pos_acc;

  // Edge detected in the sync stage is registered here: third clk edge after sampling.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      count        <= '0;
      period       <= '0;
      period_valid <= 1'b0;
      pos_acc      <= '0;
      timeout      <= 1'b0;
    end else begin
      period_valid <= 1'b0;

      if (clr_pos) begin
        pos_acc <= '0;
      end else if (counted) begin
        pos_acc <= step_pos(pos_acc, dir_lvl);
      end

      if (!drv_enable_SM) begin
        state   <= IDLE;
        count   <= '0;
        timeout <= 1'b0;
      end else begin
        case (state)
          IDLE: state <= ARMED;
          ARMED: begin
            if (step_rise) begin
              state <= MEASURE;
              count <= ONE;
            end
          end
          MEASURE: begin
            if (step_rise) begin
              period       <= count;
              period_valid <= 1'b1;
              count        <= ONE;
            end else if (count == LIMIT) begin
              // Counter parks at the limit; it never wraps.
              state   <= STALLED;
              timeout <= 1'b1;
            end else begin
              count <= count + ONE;
            end
          end
          STALLED: begin
            if (step_rise) begin
              state   <= MEASURE;
              timeout <= 1'b0;
              count   <= ONE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_step_decoder.sv
// Scoreboard bench for step_decoder: directed pulse trains, queued expectations checked on period_valid.
module tb_step_decoder;

  localparam int PW = 17;
  localparam int XW = 8;
  localparam int TO = 100;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          drv_step = 1'b0;
  logic          drv_dir = 1'b1;
  logic          drv_enable_SM = 1'b0;
  logic          clr_pos = 1'b0;
  logic [PW-1:0] period;
  logic          period_valid;
  logic [XW-1:0] position;
  logic          timeout;

  step_decoder #(.PERIOD_W(PW), .POS_W(XW), .TIMEOUT(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .drv_step      (drv_step),
    .drv_dir       (drv_dir),
    .drv_enable_SM (drv_enable_SM),
    .clr_pos       (clr_pos),
    .period        (period),
    .period_valid  (period_valid),
    .position      (position),
    .timeout       (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [PW-1:0] per;
    logic [XW-1:0] pos;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   vectors = 0;
  int   miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", name, act, act, req, req);
    end
  endtask

  task automatic push(input int per, input int pos);
    q.push_back('{per: PW'(per), pos: XW'(pos)});
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse(input int hi, input int lo);
    drv_step = 1'b1;
    tick(hi);
    drv_step = 1'b0;
    tick(lo);
  endtask

  task automatic restart();
    drv_enable_SM = 1'b0;
    tick(2);
    clr_pos = 1'b1;
    tick(1);
    clr_pos = 1'b0;
    drv_enable_SM = 1'b1;
    tick(3);
  endtask

  // Monitor: every period_valid must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst && period_valid) begin
      if (q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_valid: got period %0d position 0x%0h, required no strobe",
                 period, position);
      end else begin
        e = q.pop_front();
        check("valid_period", 32'(period), 32'(e.per));
        check("valid_position", 32'(position), 32'(e.pos));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    // Reset with step already high and enable set.
    drv_step = 1'b1;
    drv_enable_SM = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("reset_period", 32'(period), 32'd0);
    check("reset_valid", 32'(period_valid), 32'd0);
    check("reset_position", 32'(position), 32'd0);
    check("reset_timeout", 32'(timeout), 32'd0);
    tick(3);
    rst = 1'b1;
    tick(10);
    check("no_false_edge", 32'(position), 32'd0);
    drv_step = 1'b0;
    tick(3);

    // Forward, 2 high / 3 low, four pulses.
    push(5, 2);
    push(5, 3);
    push(5, 4);
    repeat (4) pulse(2, 3);
    tick(2);
    check("fwd_position", 32'(position), 32'd4);
    check("fwd_period", 32'(period), 32'd5);

    // Pulses while disabled are ignored.
    drv_enable_SM = 1'b0;
    tick(2);
    repeat (3) pulse(2, 3);
    check("disabled_hold", 32'(position), 32'd4);
    restart();
    check("period_held", 32'(period), 32'd5);
    check("position_cleared", 32'(position), 32'd0);

    // Reverse, period 20, ten pulses.
    drv_dir = 1'b0;
    tick(3);
    for (int k = 2; k <= 10; k++) push(20, -k);
    repeat (10) pulse(2, 18);
    tick(2);
    check("rev_position", 32'(position), 32'hF6);
    check("rev_period", 32'(period), 32'd20);
    restart();

    // Stall detection and recovery.
    drv_dir = 1'b1;
    tick(3);
    drv_step = 1'b1;
    tick(2);
    drv_step = 1'b0;
    for (int i = 0; i < 10 && position != 8'd1; i++) @(negedge clk);
    check("stall_first_pos", 32'(position), 32'd1);
    cnt = 0;
    while (!timeout && cnt < 300) begin
      @(negedge clk);
      cnt++;
    end
    check("timeout_latency", 32'(cnt), 32'd100);
    check("period_kept_on_stall", 32'(period), 32'd20);
    tick(50);
    check("timeout_level", 32'(timeout), 32'd1);
    pulse(2, 8);
    check("timeout_cleared", 32'(timeout), 32'd0);
    push(10, 3);
    pulse(2, 8);
    check("after_stall_position", 32'(position), 32'd3);
    restart();

    // Wrap from 127 to -128, then clear coincident with an edge.
    for (int k = 2; k <= 128; k++) push(5, k);
    repeat (128) pulse(2, 3);
    check("wrap_position", 32'(position), 32'h80);
    push(5, 0);
    drv_step = 1'b1;
    tick(2);
    drv_step = 1'b0;
    clr_pos = 1'b1;
    tick(1);
    clr_pos = 1'b0;
    tick(2);
    check("clear_wins", 32'(position), 32'd0);

    // Reset in the middle of an interval.
    push(5, 1);
    pulse(2, 3);
    drv_step = 1'b1;
    tick(1);
    #2 rst = 1'b0;
    #1;
    check("midrst_period", 32'(period), 32'd0);
    check("midrst_valid", 32'(period_valid), 32'd0);
    check("midrst_position", 32'(position), 32'd0);
    check("midrst_timeout", 32'(timeout), 32'd0);
    drv_step = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    tick(5);
    pulse(2, 3);
    push(5, 2);
    pulse(2, 3);
    check("post_reset_position", 32'(position), 32'd2);

    tick(5);
    check("queue_drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
